mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit that consumes the execute-to-memory pipeline register outputs (*_m signals).
- Performs the data access on a single-outstanding req/ready data bus.
- Formats store byte lanes and sign/zero-extends load data.
- Raises stall_m to the hazard unit until the access completes.
- Its read_data_m output feeds the memory-to-writeback pipeline register.

Parameters:
ADDRESS_WIDTH, 32, byte address width of alu_result_m and bus_addr
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
mem_write_m  in  1  store in M stage
result_src_m  in  2  2'b01 = load in M stage
funct3_m  in  3  access size/sign (RV32I encoding)
alu_result_m  in  ADDRESS_WIDTH  effective byte address
write_data_m  in  DATA_WIDTH  store data, unaligned LSBs
stall_m  out  1  freeze F/D/E/M registers; combinational
read_data_m  out  DATA_WIDTH  extended load result (registered)
fault_m  out  1  one-cycle pulse: misaligned or illegal funct3 or bus error (registered)
bus_req  out  1  access request (registered)
bus_we  out  1  1 = write (registered)
bus_addr  out  ADDRESS_WIDTH  word-aligned address, [1:0]=0 (registered)
bus_wdata  out  DATA_WIDTH  lane-replicated store data (registered)
bus_wstrb  out  4  byte write strobes; 0 on reads (registered)
bus_ready  in  1  access complete this cycle
bus_rdata  in  DATA_WIDTH  read word, valid with bus_ready
bus_err  in  1  error response, valid with bus_ready

Behaviour:
- Access definition:
  - op = mem_write_m | (result_src_m == 2'b01).
  - mem_write_m has priority if both are set.
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Legal, aligned op → load bus_* registers, go to REQ.
  - Illegal or misaligned op → stay IDLE, fault_m=1 next cycle, no bus access, read_data_m unchanged, stall_m=0.
  - No op → stay IDLE.
- REQ:
  - bus_req=1, all bus_* held stable until bus_ready.
  - On bus_ready, go to DONE.
  - If it was a load, register the extended bus_rdata into read_data_m at the same edge.
  - If bus_err is set, read_data_m=0 and fault_m=1 during the DONE cycle.
  - bus_req drops at the same edge.
- DONE: one cycle, then return to IDLE unconditionally.
- stall_m = (state==IDLE & legal aligned op) | (state==REQ).
  - Deasserted in DONE so the pipeline advances exactly once.
  - The next M-stage op is seen in the following IDLE cycle.
- Latency: zero-wait-state access = 3 cycles in M (2 stalled). Each bus wait cycle adds 1.
- Store lanes (o = addr[1:0]):
  - sb: wstrb = 4'b0001<<o, wdata = {4{wd[7:0]}}.
  - sh: wstrb = 4'b0011<<o, wdata = {2{wd[15:0]}}.
  - sw: wstrb = 4'b1111, wdata = wd.
- Load extract: select byte o / halfword o[1] from bus_rdata. lb/lh sign-extend; lbu/lhu zero-extend.
- read_data_m holds its value until the next successful load or bus-error load.
- Reset (asynchronous, any state including REQ mid-transaction):
  - state=IDLE.
  - Zeroed: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, read_data_m, fault_m.
  - The outstanding transaction is abandoned; the bus is responsible for tolerating request withdrawal.
- bus_ready outside REQ is ignored.
- Inputs are assumed stable while stall_m=1; the unit does not re-sample them in REQ.

Test Plan:
- Reset: assert rst mid-REQ → bus_req, stall_m, read_data_m, fault_m all 0 within the same cycle, and state IDLE after release.
- Load word: lw addr 0x1004, bus_ready same cycle, rdata 0xDEADBEEF → stall_m high 2 cycles; read_data_m=0xDEADBEEF; bus_addr=0x1004, bus_wstrb=0.
- Sign/zero extension with rdata 0x80FF7F01:
  - lb @0x2003 → 0xFFFFFF80
  - lbu @0x2003 → 0x00000080
  - lh @0x2002 → 0xFFFF80FF
  - lhu @0x2000 → 0x00007F01
- Stores with wd=0x11223344:
  - sb @0x3001 → wstrb 0010, wdata 0x44444444
  - sh @0x3002 → wstrb 1100, wdata 0x33443344
  - sw @0x3000 → wstrb 1111
  - bus_ready delayed 3 cycles → stall_m 5 cycles, bus signals stable throughout.
- Faults:
  - lw @0x4002 → fault_m 1-cycle pulse, no bus_req, stall_m never asserted.
  - funct3=011 store → same response.
  - lw with bus_err → read_data_m=0, fault_m pulse in DONE.
- Back-to-back sw then lw → two separate REQ phases separated by DONE→IDLE; the second op begins the cycle after DONE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one outstanding req/ready bus access, store lane formatting, load extension.
// Zero-wait access takes 3 cycles in M (IDLE, REQ, DONE); stall_m holds the pipeline until DONE.
module mem_stage_lsu #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_write_m,
  input  logic [1:0]               result_src_m,
  input  logic [2:0]               funct3_m,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
  input  logic [DATA_WIDTH-1:0]    write_data_m,
  output logic                     stall_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic                     fault_m,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [ADDRESS_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0]    bus_wdata,
  output logic [3:0]               bus_wstrb,
  input  logic                     bus_ready,
  input  logic [DATA_WIDTH-1:0]    bus_rdata,
  input  logic                     bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_next;
  logic            op, legal, aligned, start, reject, resp;
  logic [2:0]      acc_funct3;
  logic [1:0]      acc_off;
  logic [1:0]      off;
  logic [31:0]     store_data;
  logic [3:0]      store_strb;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     load_data;

  assign op   = mem_write_m | (result_src_m == 2'b01);
  assign off  = alu_result_m[1:0];
  assign resp = (state == REQ) & bus_ready;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    if (mem_write_m) legal = (funct3_m == 3'b000) | (funct3_m == 3'b001) | (funct3_m == 3'b010);
    else             legal = funct3_m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    if (funct3_m[1:0] == 2'b01)      aligned = ~off[0];
    else if (funct3_m[1:0] == 2'b10) aligned = (off == 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: if (op) begin
        if (legal & aligned) begin
          start      = 1'b1;
          state_next = REQ;
        end else begin
          reject = 1'b1;
        end
      end
      REQ:     if (bus_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Gated by rst so an abandoned access never leaves the pipeline frozen.
    stall_m = ~rst & (start | (state == REQ));
  end

  always_comb begin
    case (funct3_m[1:0])
      2'b00: begin
        store_data = {4{write_data_m[7:0]}};
        store_strb = 4'b0001 << off;
      end
      2'b01: begin
        store_data = {2{write_data_m[15:0]}};
        store_strb = 4'b0011 << off;
      end
      default: begin
        store_data = write_data_m;
        store_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (acc_off)
      2'b00:   ld_byte = bus_rdata[7:0];
      2'b01:   ld_byte = bus_rdata[15:8];
      2'b10:   ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = acc_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (acc_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= 4'b0000;
      read_data_m <= '0;
      fault_m     <= 1'b0;
      acc_funct3  <= 3'b000;
      acc_off     <= 2'b00;
    end else begin
      fault_m <= reject | (resp & bus_err);
      if (start) begin
        bus_req    <= 1'b1;
        bus_we     <= mem_write_m;
        bus_addr   <= {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
        bus_wdata  <= store_data;
        bus_wstrb  <= mem_write_m ? store_strb : 4'b0000;
        acc_funct3 <= funct3_m;
        acc_off    <= off;
      end else if (resp) begin
        bus_req <= 1'b0;
        if (!bus_we) read_data_m <= bus_err ? '0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed + random bench for mem_stage_lsu; expectations come from an arithmetic model of the
// access rules (legality, lanes, extension, cycle counts), never from the DUT.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic        stall_m;
  logic [31:0] read_data_m;
  logic        fault_m;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rd = 32'd0;

  mem_stage_lsu #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m), .funct3_m(funct3_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .stall_m(stall_m), .read_data_m(read_data_m), .fault_m(fault_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * o)) & 32'hFF;
    h = (rd >> (16 * o[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  task automatic no_op();
    mem_write_m  = 1'b0;
    result_src_m = 2'b00;
    funct3_m     = 3'b000;
  endtask

  // One M-stage access from an IDLE cycle through DONE (or through the fault pulse).
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] rdata,
                        input bit err);
    bit legal, aligned;
    int size, stalls;
    logic [1:0]  o;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    o = addr[1:0];
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    aligned = (addr % size) == 0;
    e_wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 : (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    e_strb  = we ? 4'((2 ** size - 1) << ((size == 4) ? 0 : o)) : 4'd0;

    @(negedge clk);
    mem_write_m  = we;
    result_src_m = we ? 2'($urandom_range(0, 3)) : 2'b01;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    bus_ready    = 1'b0;
    bus_err      = 1'b0;
    #1;
    check("idle_fault_low", fault_m, 1'b0);
    check("idle_bus_req", bus_req, 1'b0);
    if (!(legal && aligned)) begin
      check("fault_no_stall", stall_m, 1'b0);
      @(negedge clk);
      no_op();
      #1;
      check("fault_pulse", fault_m, 1'b1);
      check("fault_no_req", bus_req, 1'b0);
      check("fault_rd_kept", read_data_m, exp_rd);
      check("fault_no_stall2", stall_m, 1'b0);
      @(negedge clk);
      #1;
      check("fault_pulse_end", fault_m, 1'b0);
      check("fault_no_req2", bus_req, 1'b0);
      return;
    end
    stalls = stall_m ? 1 : 0;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      if (i == waits) begin
        bus_ready = 1'b1;
        bus_rdata = rdata;
        bus_err   = err;
      end else begin
        bus_rdata = $urandom;
        bus_err   = 1'($urandom_range(0, 1));
      end
      #1;
      if (stall_m) stalls++;
      check("req_high", bus_req, 1'b1);
      check("req_we", bus_we, we);
      check("req_addr", bus_addr, addr & 32'hFFFF_FFFC);
      check("req_wstrb", bus_wstrb, e_strb);
      if (we) check("req_wdata", bus_wdata, e_wdata);
    end
    if (!we) exp_rd = err ? 32'd0 : ext(f3, o, rdata);
    @(negedge clk);
    bus_ready = 1'b0;
    bus_err   = 1'b0;
    bus_rdata = $urandom;
    #1;
    check("done_stall_low", stall_m, 1'b0);
    check("done_req_low", bus_req, 1'b0);
    check("done_fault", fault_m, err);
    check("done_read_data", read_data_m, exp_rd);
    check("stall_cycles", stalls, waits + 2);
  endtask

  initial begin
    rst = 1'b1;
    no_op();
    alu_result_m = 32'd0;
    write_data_m = 32'd0;
    bus_ready    = 1'b0;
    bus_rdata    = 32'd0;
    bus_err      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_stall", stall_m, 1'b0);
    check("rst_read_data", read_data_m, 32'd0);
    check("rst_fault", fault_m, 1'b0);
    check("rst_wstrb", bus_wstrb, 4'd0);
    check("rst_addr", bus_addr, 32'd0);
    rst = 1'b0;

    // Directed loads
    access(0, 3'b010, 32'h0000_1004, 32'd0, 0, 32'hDEAD_BEEF, 0);
    access(0, 3'b000, 32'h0000_2003, 32'd0, 0, 32'h80FF_7F01, 0);
    access(0, 3'b100, 32'h0000_2003, 32'd0, 1, 32'h80FF_7F01, 0);
    access(0, 3'b001, 32'h0000_2002, 32'd0, 0, 32'h80FF_7F01, 0);
    access(0, 3'b101, 32'h0000_2000, 32'd0, 2, 32'h80FF_7F01, 0);
    check("lhu_value", read_data_m, 32'h0000_7F01);
    // Directed stores
    access(1, 3'b000, 32'h0000_3001, 32'h1122_3344, 0, 32'd0, 0);
    access(1, 3'b001, 32'h0000_3002, 32'h1122_3344, 0, 32'd0, 0);
    access(1, 3'b010, 32'h0000_3000, 32'h1122_3344, 3, 32'd0, 0);
    // Faults
    access(0, 3'b010, 32'h0000_4002, 32'd0, 0, 32'd0, 0);
    access(1, 3'b011, 32'h0000_4000, 32'h1234_5678, 0, 32'd0, 0);
    access(0, 3'b110, 32'h0000_4000, 32'd0, 0, 32'd0, 0);
    access(0, 3'b010, 32'h0000_1008, 32'd0, 1, 32'h1357_9BDF, 1);
    // Back-to-back sw then lw
    access(1, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, 0, 32'd0, 0);
    access(0, 3'b010, 32'h0000_5000, 32'd0, 0, 32'hCAFE_F00D, 0);

    // bus_ready outside REQ is ignored
    @(negedge clk);
    no_op();
    bus_ready = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    #1;
    @(negedge clk);
    #1;
    check("stray_ready_req", bus_req, 1'b0);
    check("stray_ready_rd", read_data_m, exp_rd);
    check("stray_ready_stall", stall_m, 1'b0);
    bus_ready = 1'b0;

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        no_op();
      end
    end

    // Reset while a load is in REQ
    access(0, 3'b010, 32'h0000_6000, 32'd0, 0, 32'h0BAD_CAFE, 0);
    @(negedge clk);
    mem_write_m  = 1'b0;
    result_src_m = 2'b01;
    funct3_m     = 3'b010;
    alu_result_m = 32'h0000_6004;
    @(negedge clk);
    #1;
    check("pre_rst_in_req", bus_req, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_bus_req", bus_req, 1'b0);
    check("mid_rst_stall", stall_m, 1'b0);
    check("mid_rst_read_data", read_data_m, 32'd0);
    check("mid_rst_fault", fault_m, 1'b0);
    exp_rd = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    no_op();
    @(negedge clk);
    #1;
    check("post_rst_req", bus_req, 1'b0);
    check("post_rst_stall", stall_m, 1'b0);
    access(0, 3'b000, 32'h0000_7001, 32'd0, 0, 32'h0000_8000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
